// File: rtl/mvu_mem_bridge.sv
// Bridges a 32-bit word-granular memory port onto one wider MVU memory port.
// Steers lanes, expands byte enables and tracks the fixed-latency responses.
module mvu_mem_bridge #(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned RegionBits   = 25,
  parameter int unsigned MvuDataWidth = 64,
  parameter int unsigned MvuAddrWidth = 15,
  parameter int unsigned ReadLatency  = 2,
  parameter logic [31:0] ErrData      = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  output logic                      gnt_o,
  input  logic                      we_i,
  input  logic [AddrWidth-1:0]      addr_i,
  input  logic [31:0]               wdata_i,
  input  logic [3:0]                be_i,
  output logic [31:0]               rdata_o,
  output logic                      rvalid_o,
  output logic                      mvu_req_o,
  input  logic                      mvu_gnt_i,
  output logic                      mvu_we_o,
  output logic [MvuAddrWidth-1:0]   mvu_addr_o,
  output logic [MvuDataWidth-1:0]   mvu_wdata_o,
  output logic [MvuDataWidth/8-1:0] mvu_be_o,
  input  logic [MvuDataWidth-1:0]   mvu_rdata_i,
  output logic [15:0]               err_cnt_o
);

  localparam int unsigned BeWidth = MvuDataWidth / 8;
  localparam int unsigned B       = $clog2(BeWidth);
  localparam int unsigned L       = MvuDataWidth / 32;
  localparam int unsigned LaneW   = (B > 2) ? B - 2 : 1;
  localparam int unsigned HiLsb   = B + MvuAddrWidth;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic             oow;
    logic [LaneW-1:0] lane;
  } rsp_t;

  logic [LaneW-1:0]   lane;
  logic               oow;
  logic [BeWidth-1:0] be_wide;
  rsp_t               push;
  rsp_t               tail;
  rsp_t [ReadLatency-1:0] pipe;
  logic [31:0]        lane_data;

  if (B > 2) begin : g_lane
    assign lane = addr_i[B-1:2];
  end else begin : g_nolane
    assign lane = '0;
  end

  if (HiLsb < RegionBits) begin : g_win
    assign oow = |addr_i[RegionBits-1:HiLsb];
  end else begin : g_nowin
    assign oow = 1'b0;
  end

  if (AddrWidth > RegionBits) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^addr_i[AddrWidth-1:RegionBits];
  end

  logic unused_lo;
  assign unused_lo = ^addr_i[1:0];

  assign be_wide = BeWidth'(be_i);

  always_comb begin
    mvu_req_o   = 1'b0;
    gnt_o       = 1'b0;
    mvu_we_o    = 1'b0;
    mvu_addr_o  = '0;
    mvu_wdata_o = '0;
    mvu_be_o    = '0;
    if (!rst_i && req_i) begin
      if (oow) begin
        // Dropped locally so the upstream never waits on the arbiter
        gnt_o = 1'b1;
      end else begin
        mvu_req_o   = 1'b1;
        gnt_o       = mvu_gnt_i;
        mvu_we_o    = we_i;
        mvu_addr_o  = addr_i[HiLsb-1:B];
        mvu_wdata_o = {L{wdata_i}};
        mvu_be_o    = we_i ? (be_wide << {lane, 2'b00}) : '1;
      end
    end
  end

  always_comb begin
    push       = '0;
    push.valid = gnt_o;
    push.we    = we_i;
    push.oow   = oow;
    push.lane  = lane;
  end

  assign tail      = pipe[ReadLatency-1];
  assign lane_data = mvu_rdata_i[{tail.lane, 5'b0} +: 32];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe      <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_cnt_o <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < int'(ReadLatency); i++) begin
        pipe[i] <= pipe[i-1];
      end
      rvalid_o <= tail.valid;
      if (tail.valid) begin
        if (tail.oow) begin
          rdata_o <= ErrData;
        end else if (tail.we) begin
          rdata_o <= '0;
        end else begin
          rdata_o <= lane_data;
        end
      end
      if (gnt_o && oow && err_cnt_o != 16'hFFFF) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mvu_mem_bridge.sv
// Directed bench for mvu_mem_bridge: 64-bit MVU word, read latency 2.
// A scoreboard queue holds the expected response cycle and data per grant.
module tb_mvu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic        mvu_req_o;
  logic        mvu_gnt_i;
  logic        mvu_we_o;
  logic [14:0] mvu_addr_o;
  logic [63:0] mvu_wdata_o;
  logic [7:0]  mvu_be_o;
  logic [63:0] mvu_rdata_i;
  logic [15:0] err_cnt_o;

  mvu_mem_bridge dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .rdata_o     (rdata_o),
    .rvalid_o    (rvalid_o),
    .mvu_req_o   (mvu_req_o),
    .mvu_gnt_i   (mvu_gnt_i),
    .mvu_we_o    (mvu_we_o),
    .mvu_addr_o  (mvu_addr_o),
    .mvu_wdata_o (mvu_wdata_o),
    .mvu_be_o    (mvu_be_o),
    .mvu_rdata_i (mvu_rdata_i),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Memory model: each 32-bit slot holds 0x1000_0000 + (byte addr >> 2)
  function automatic logic [63:0] mem_rd(input logic [14:0] w);
    logic [31:0] base;
    if (w == 15'd2) return 64'h1111_2222_3333_4444;
    base = 32'h1000_0000 + {16'h0, w, 1'b0};
    return {base + 32'd1, base};
  endfunction

  logic [63:0] rd0 = '0;
  logic [63:0] rd1 = '0;
  assign mvu_rdata_i = rd1;

  always @(posedge clk) begin
    rd1 <= rd0;
    rd0 <= (mvu_req_o && mvu_gnt_i && !mvu_we_o) ? mem_rd(mvu_addr_o) : '0;
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (rvalid_o) begin
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", 64'(rvalid_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
          check("rdata", 64'(rdata_o), 64'(e.data));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check("missing_rvalid", 64'(rvalid_o), 64'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] b,
                      input logic [31:0] exp, input int stall);
    req_i   = 1'b1;
    we_i    = w;
    addr_i  = a;
    wdata_i = wd;
    be_i    = b;
    for (int n = 0; n <= stall; n++) begin
      mvu_gnt_i = (n == stall);
      #1;
      if (n < stall) begin
        check("stall_gnt", 64'(gnt_o), 64'd0);
        @(negedge clk);
      end else begin
        check("gnt", 64'(gnt_o), 64'd1);
      end
    end
    if (gnt_o) exp_q.push_back('{cyc: cyc + 3, data: exp});
  endtask

  task automatic idle(input int n);
    req_i = 1'b0;
    we_i  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_i     = 1'b1;
    req_i     = 1'b1;
    we_i      = 1'b1;
    addr_i    = 32'h7000_0014;
    wdata_i   = 32'h0;
    be_i      = 4'hF;
    mvu_gnt_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mvu_req", 64'(mvu_req_o), 64'd0);
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_be", 64'(mvu_be_o), 64'd0);
    check("rst_rvalid", 64'(rvalid_o), 64'd0);
    check("rst_rdata", 64'(rdata_o), 64'd0);
    check("rst_err", 64'(err_cnt_o), 64'd0);
    @(negedge clk);
    rst_i = 1'b0;
    idle(2);

    xfer(1'b1, 32'h7000_0014, 32'hA5A5_1234, 4'hF, 32'h0, 0);
    check("wr_mvu_req", 64'(mvu_req_o), 64'd1);
    check("wr_mvu_we", 64'(mvu_we_o), 64'd1);
    check("wr_addr", 64'(mvu_addr_o), 64'd2);
    check("wr_be_lane1", 64'(mvu_be_o), 64'hF0);
    check("wr_wdata", mvu_wdata_o, 64'hA5A5_1234_A5A5_1234);
    @(negedge clk);
    xfer(1'b1, 32'h7000_0010, 32'h0BAD_F00D, 4'h3, 32'h0, 0);
    check("wr_be_lane0", 64'(mvu_be_o), 64'h03);
    @(negedge clk);
    idle(5);

    xfer(1'b0, 32'h7000_0014, 32'h0, 4'h0, 32'h1111_2222, 0);
    check("rd_be", 64'(mvu_be_o), 64'hFF);
    check("rd_mvu_we", 64'(mvu_we_o), 64'd0);
    @(negedge clk);
    xfer(1'b0, 32'h7000_0010, 32'h0, 4'h0, 32'h3333_4444, 0);
    @(negedge clk);
    idle(5);

    xfer(1'b0, 32'h7000_0014, 32'h0, 4'h0, 32'h1111_2222, 5);
    @(negedge clk);
    idle(6);

    xfer(1'b0, 32'h7100_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    check("oow_mvu_req", 64'(mvu_req_o), 64'd0);
    @(negedge clk);
    req_i = 1'b0;
    #1;
    check("oow_err_cnt", 64'(err_cnt_o), 64'd1);
    idle(5);

    xfer(1'b0, 32'h7000_0010, 32'h0, 4'h0, 32'h3333_4444, 0);
    @(negedge clk);
    xfer(1'b0, 32'h7100_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    xfer(1'b0, 32'h7000_0014, 32'h0, 4'h0, 32'h1111_2222, 0);
    @(negedge clk);
    idle(5);
    check("ilv_err_cnt", 64'(err_cnt_o), 64'd2);

    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 32'h7000_0020 + 32'(4 * i), 32'h0, 4'h0,
           32'h1000_0008 + 32'(i), 0);
      @(negedge clk);
    end
    idle(5);

    xfer(1'b0, 32'h7000_0040, 32'h0, 4'h0, 32'h1000_0010, 0);
    @(negedge clk);
    xfer(1'b0, 32'h7000_0044, 32'h0, 4'h0, 32'h1000_0011, 0);
    @(negedge clk);
    req_i = 1'b0;
    rst_i = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    idle(6);
    check("post_rst_rvalid", 64'(rvalid_o), 64'd0);
    check("post_rst_err", 64'(err_cnt_o), 64'd0);

    for (int i = 0; i < 65540; i++) begin
      xfer(1'b1, 32'h7100_0004, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 0);
      @(negedge clk);
    end
    idle(6);
    check("sat_err_cnt", 64'(err_cnt_o), 64'hFFFF);
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mvu_mem_bridge.md
# mvu_mem_bridge

Adapts one 32-bit word-granular memory port from an AXI-to-memory converter to one MVU memory port that is MvuDataWidth bits wide with fixed read latency.
- Sits between the MVUnMEM crossbar leg's memory-side output and the MVU memory arbiter input.
- Handles lane steering, byte-enable expansion and fixed-latency response tracking.
- Catches out-of-window addresses locally and returns a defined response for them, so the AXI side never hangs.

## Interface
- AddrWidth, 32: byte-address width of the upstream port.
- RegionBits, 25: log2 of the MVU region size in bytes (0x0200_0000).
- MvuDataWidth, 64: MVU word width in bits; a power of two, at least 32.
- MvuAddrWidth, 15: MVU word-address width. Must satisfy MvuAddrWidth + log2(MvuDataWidth/8) <= RegionBits.
- ReadLatency, 2: cycles from an MVU grant to valid mvu_rdata_i; at least 1.
- ErrData, 32'hDEAD_BEEF: read data returned for out-of-window reads.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  upstream request.
- gnt_o  out  1  upstream grant.
- we_i  in  1  write enable.
- addr_i  in  AddrWidth  byte address.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables.
- rdata_o  out  32  response data.
- rvalid_o  out  1  response valid; one pulse per granted request, reads and writes alike.
- mvu_req_o  out  1  MVU request.
- mvu_gnt_i  in  1  MVU grant (from the arbiter; may stall).
- mvu_we_o  out  1  MVU write enable.
- mvu_addr_o  out  MvuAddrWidth  MVU word address.
- mvu_wdata_o  out  MvuDataWidth  MVU write data.
- mvu_be_o  out  MvuDataWidth/8  MVU byte enables.
- mvu_rdata_i  in  MvuDataWidth  MVU read data.
- err_cnt_o  out  16  saturating count of out-of-window accesses.

## Operation
- Address fields, with B = log2(MvuDataWidth/8) and L = MvuDataWidth/32:
  - lane = addr_i[B-1:2]
  - word = addr_i[B+MvuAddrWidth-1:B]
  - in-window when addr_i[RegionBits-1:B+MvuAddrWidth] == 0
  - addr_i[1:0] is ignored; bits at and above RegionBits are ignored (the crossbar has already decoded them).
- In-window request:
  - mvu_req_o = req_i; gnt_o = req_i & mvu_gnt_i.
  - mvu_addr_o = word; mvu_we_o = we_i.
  - mvu_wdata_o = wdata_i replicated L times.
  - mvu_be_o = be_i in 4-bit lane field `lane`, zero elsewhere. Reads drive mvu_be_o to all ones.
- Out-of-window request:
  - mvu_req_o = 0; gnt_o = req_i (granted immediately).
  - Writes are dropped.
  - err_cnt_o increments and saturates at 16'hFFFF.
- Response pipeline:
  - Each grant pushes {valid, we, oow, lane} into a ReadLatency-deep shift register.
  - Non-granted cycles push valid = 0.
  - At the stage ReadLatency (aligned with mvu_rdata_i), an output register loads:
    - rvalid_o = 1
    - rdata_o = ErrData if oow; else 32'h0 if we; else mvu_rdata_i[32*lane +: 32].
- Ordering is preserved: out-of-window entries use the same pipeline, so responses return strictly in grant order.
- Throughput is one grant per cycle. The response side has no backpressure; the upstream port always accepts rvalid_o.
- Reset:
  - Clears the pipeline, rvalid_o, rdata_o (32'h0) and err_cnt_o (0).
  - In-flight responses are discarded.
  - Combinational request outputs follow req_i; mvu_req_o, gnt_o and the other MVU outputs are forced to 0 while rst_i is high.

## Timing
- Grant is combinational with the request.
- rvalid_o rises exactly ReadLatency+1 cycles after the grant cycle, for both in-window and out-of-window requests.
- Back-to-back grants give back-to-back rvalid_o pulses with no bubbles.
- While mvu_gnt_i = 0, an in-window request holds with gnt_o = 0 and nothing is pushed; the upstream port must keep req/addr/wdata stable.
- When an error increment coincides with reset, reset wins.
- err_cnt_o updates the cycle after the grant.

## Test plan
- **In-window write, lane 1**: MvuDataWidth = 64, ReadLatency = 2. Write addr 0x7000_0014, wdata 0xA5A5_1234, be 4'hF, mvu_gnt_i = 1.
  - Same cycle: mvu_addr_o = 2, mvu_be_o = 8'hF0, mvu_wdata_o = 64'hA5A5_1234_A5A5_1234.
  - rvalid_o = 1 with rdata_o = 0 three cycles later.
- **In-window read, lane 1**: read addr 0x7000_0014; model drives mvu_rdata_i = 64'h1111_2222_3333_4444 two cycles after the grant.
  - One cycle later: rvalid_o = 1, rdata_o = 32'h1111_2222.
  - Lane 0 (addr 0x7000_0010) returns 32'h3333_4444.
- **Stall**: hold mvu_gnt_i = 0 for 5 cycles under a read request.
  - gnt_o = 0 and no rvalid_o during the stall.
  - After the grant, exactly one rvalid_o, at grant + 3.
- **Out-of-window**: read addr 0x7100_0000 (word bits above MvuAddrWidth nonzero).
  - mvu_req_o = 0; gnt_o = 1 in the same cycle.
  - rdata_o = 32'hDEAD_BEEF at grant + 3; err_cnt_o = 1.
  - An interleaved in-window read/out-of-window read/in-window read sequence returns responses in order.
- **Streaming + reset**: stream 8 back-to-back reads at consecutive addresses.
  - 8 consecutive rvalid_o pulses with correct lanes.
  - Assert rst_i with 2 responses in flight: no rvalid_o afterward, err_cnt_o = 0.
- **Saturation**: issue 65 540 out-of-window writes; err_cnt_o holds at 16'hFFFF.
